// File: rtl/alarm_ring_cont.sv
// alarm_ring_cont: watches the running time against the programmed alarm time.
// When they match it rings for a bounded number of seconds. It handles stop and
// snooze requests and drives a square-wave buzzer plus ring and snooze status.
// Request pulses STOP / SNOOZE / SEC_TICK are single-CLK strobes with no handshake:
// they act in the cycle they are high and are otherwise ignored.
module alarm_ring_cont #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int BUZ_DIV    = 1000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [16:0] CUR_TIME,
  input  logic [16:0] ALARM_TIME,
  input  logic        ALARM_EN,
  input  logic        SEC_TICK,
  input  logic        STOP,
  input  logic        SNOOZE,
  output logic        RINGING,
  output logic        BUZZER,
  output logic        SNOOZE_ACT,
  output logic [3:0]  SNOOZE_LEFT,
  output logic [1:0]  STATE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  // Terminal values: a counter sitting at *_LAST plus one SEC_TICK completes the phase.
  localparam logic [15:0] RING_LAST = 16'(RING_SEC - 1);
  localparam logic [15:0] SNZ_LAST  = 16'(SNOOZE_SEC - 1);
  localparam logic [15:0] BUZ_LAST  = 16'(BUZ_DIV - 1);
  localparam logic [3:0]  MAX_LEFT  = 4'(MAX_SNOOZE);

  state_e      state_q, state_d;
  logic        match_q;
  logic [15:0] ring_cnt_q, ring_cnt_d;
  logic [15:0] snz_cnt_q, snz_cnt_d;
  logic [15:0] buz_cnt_q, buz_cnt_d;
  logic        buzzer_q, buzzer_d;
  logic [3:0]  snooze_left_q, snooze_left_d;

  logic match;
  logic trigger;

  // Only a fresh rising edge of the match starts an event, so a held match cannot retrigger.
  assign match   = ALARM_EN && (CUR_TIME == ALARM_TIME);
  assign trigger = match && !match_q;

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= ST_IDLE;
      match_q       <= 1'b0;
      ring_cnt_q    <= 16'd0;
      snz_cnt_q     <= 16'd0;
      buz_cnt_q     <= 16'd0;
      buzzer_q      <= 1'b0;
      snooze_left_q <= MAX_LEFT;
    end else begin
      state_q       <= state_d;
      match_q       <= match;
      ring_cnt_q    <= ring_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      buz_cnt_q     <= buz_cnt_d;
      buzzer_q      <= buzzer_d;
      snooze_left_q <= snooze_left_d;
    end
  end

  // Next-state logic; priority is !ALARM_EN > STOP > SNOOZE > timeout > tick counting.
  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snz_cnt_d     = snz_cnt_q;
    snooze_left_d = snooze_left_q;
    // Buzzer is zeroed on every path that does not stay in RING, which also
    // covers clearing it on each entry into RING.
    buz_cnt_d     = 16'd0;
    buzzer_d      = 1'b0;

    if (!ALARM_EN) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d       = ST_RING;
            ring_cnt_d    = 16'd0;
            snooze_left_d = MAX_LEFT;
          end
        end
        ST_RING: begin
          if (STOP) begin
            state_d = ST_DONE;
          end else if (SNOOZE) begin
            if (snooze_left_q != 4'd0) begin
              state_d       = ST_SNOOZE;
              snooze_left_d = snooze_left_q - 4'd1;
              snz_cnt_d     = 16'd0;
            end else begin
              // No snoozes left: the request behaves as a stop.
              state_d = ST_DONE;
            end
          end else if (SEC_TICK && (ring_cnt_q == RING_LAST)) begin
            state_d    = ST_DONE;
            ring_cnt_d = ring_cnt_q + 16'd1;
          end else begin
            if (SEC_TICK) begin
              ring_cnt_d = ring_cnt_q + 16'd1;
            end
            if (buz_cnt_q == BUZ_LAST) begin
              buz_cnt_d = 16'd0;
              buzzer_d  = ~buzzer_q;
            end else begin
              buz_cnt_d = buz_cnt_q + 16'd1;
              buzzer_d  = buzzer_q;
            end
          end
        end
        ST_SNOOZE: begin
          if (STOP) begin
            state_d = ST_DONE;
          end else if (SEC_TICK) begin
            snz_cnt_d = snz_cnt_q + 16'd1;
            if (snz_cnt_q == SNZ_LAST) begin
              state_d    = ST_RING;
              ring_cnt_d = 16'd0;
            end
          end
        end
        ST_DONE: begin
          if (!match) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign RINGING     = (state_q == ST_RING);
  assign SNOOZE_ACT  = (state_q == ST_SNOOZE);
  assign BUZZER      = buzzer_q;
  assign SNOOZE_LEFT = snooze_left_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_alarm_ring_cont.sv
// tb_alarm_ring_cont: directed scenarios plus randomized traffic against a
// behavioural model of the alarm ring controller.
module tb_alarm_ring_cont;

  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 2;
  localparam int MAX_SNOOZE = 1;
  localparam int BUZ_DIV    = 4;

  localparam logic [16:0] ALM    = {1'b1, 4'd7, 6'd30, 6'd0};
  localparam logic [16:0] BEFORE = {1'b1, 4'd7, 6'd29, 6'd59};
  localparam logic [16:0] AFTER  = {1'b1, 4'd7, 6'd30, 6'd1};
  localparam logic [8:0]  RST_VEC = {3'b000, 4'(MAX_SNOOZE), 2'b00};

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [16:0] CUR_TIME = '0;
  logic [16:0] ALARM_TIME = '0;
  logic        ALARM_EN = 1'b0;
  logic        SEC_TICK = 1'b0;
  logic        STOP = 1'b0;
  logic        SNOOZE = 1'b0;
  logic        RINGING, BUZZER, SNOOZE_ACT;
  logic [3:0]  SNOOZE_LEFT;
  logic [1:0]  STATE;
  logic [8:0]  dut_vec;

  always #5 CLK = ~CLK;

  alarm_ring_cont #(
    .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC),
    .MAX_SNOOZE(MAX_SNOOZE), .BUZ_DIV(BUZ_DIV)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .CUR_TIME(CUR_TIME), .ALARM_TIME(ALARM_TIME),
    .ALARM_EN(ALARM_EN), .SEC_TICK(SEC_TICK), .STOP(STOP), .SNOOZE(SNOOZE),
    .RINGING(RINGING), .BUZZER(BUZZER), .SNOOZE_ACT(SNOOZE_ACT),
    .SNOOZE_LEFT(SNOOZE_LEFT), .STATE(STATE)
  );

  assign dut_vec = {RINGING, BUZZER, SNOOZE_ACT, SNOOZE_LEFT, STATE};

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 ringing, 2 snoozing, 3 done
  int m_mode, m_secs, m_left, m_cycles;
  bit m_prev;

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_left = MAX_SNOOZE; m_cycles = 0; m_prev = 1'b0;
  endtask

  // m_secs counts whole seconds spent in the current ring or snooze phase;
  // m_cycles counts clocks since the ring phase began (buzzer phase).
  task automatic model_update(input bit en, input logic [16:0] cur, input logic [16:0] alm,
                              input bit tick, input bit stop, input bit snz);
    bit match, trig;
    match  = en && (cur == alm);
    trig   = match && !m_prev;
    m_prev = match;
    if (!en) m_mode = 0;
    else begin
      case (m_mode)
        0: if (trig) begin m_mode = 1; m_secs = 0; m_left = MAX_SNOOZE; m_cycles = 0; end
        1: begin
          if (stop) m_mode = 3;
          else if (snz) begin
            if (m_left > 0) begin m_left = m_left - 1; m_mode = 2; m_secs = 0; end
            else m_mode = 3;
          end else begin
            if (tick) m_secs = m_secs + 1;
            if (m_secs == RING_SEC) m_mode = 3;
            else m_cycles = m_cycles + 1;
          end
        end
        2: begin
          if (stop) m_mode = 3;
          else if (tick) begin
            m_secs = m_secs + 1;
            if (m_secs == SNOOZE_SEC) begin m_mode = 1; m_secs = 0; m_cycles = 0; end
          end
        end
        default: if (!match) m_mode = 0;
      endcase
    end
  endtask

  function automatic logic [8:0] model_vec();
    logic bz;
    bz = (m_mode == 1) && (((m_cycles / BUZ_DIV) % 2) == 1);
    return {(m_mode == 1), bz, (m_mode == 2), 4'(m_left), 2'(m_mode)};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: inputs are held across the edge, model advances, outputs settle.
  task automatic step();
    bit rst_n, en, tick, stop, snz;
    logic [16:0] cur, alm;
    rst_n = RESETN; en = ALARM_EN; tick = SEC_TICK; stop = STOP; snz = SNOOZE;
    cur = CUR_TIME; alm = ALARM_TIME;
    @(posedge CLK);
    if (!rst_n) model_reset();
    else model_update(en, cur, alm, tick, stop, snz);
    #1;
  endtask

  // Produce a fresh match rising edge (from IDLE or DONE) so the alarm rings.
  task automatic fresh_ring();
    ALARM_EN = 1'b1; ALARM_TIME = ALM;
    CUR_TIME = AFTER;  step();
    CUR_TIME = BEFORE; step();
    CUR_TIME = ALM;    step();
  endtask

  task automatic pulse_tick();
    SEC_TICK = 1'b1; step(); SEC_TICK = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    RESETN = 1'b0;
    step(); step();
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL reset_values: got %b expected %b", dut_vec, RST_VEC);
    end
    RESETN = 1'b1;
    step();
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL reset_release: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_basic_ring();
    ALARM_TIME = ALM; ALARM_EN = 1'b1; CUR_TIME = BEFORE;
    step();
    checks++;
    if (STATE !== 2'b00) begin
      errors++; $display("FAIL idle_before_match: got %b expected 00", STATE);
    end
    CUR_TIME = ALM;
    step();
    checks++;
    if (RINGING !== 1'b1 || BUZZER !== 1'b0) begin
      errors++; $display("FAIL ring_latency: got ringing=%b buzzer=%b expected 1 0", RINGING, BUZZER);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL buzzer_cycle%0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    for (int t = 0; t < RING_SEC; t++) begin
      pulse_tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL ring_tick%0d: got %b expected %b", t, dut_vec, model_vec());
      end
      step();
    end
    checks++;
    if (STATE !== 2'b11 || RINGING !== 1'b0 || BUZZER !== 1'b0) begin
      errors++; $display("FAIL ring_timeout: got state=%b ringing=%b buzzer=%b expected 11 0 0",
                         STATE, RINGING, BUZZER);
    end
  endtask

  task automatic test_snooze();
    fresh_ring();
    SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
    checks++;
    if (SNOOZE_ACT !== 1'b1 || SNOOZE_LEFT !== 4'd0 || RINGING !== 1'b0) begin
      errors++; $display("FAIL snooze_enter: got act=%b left=%0d ring=%b expected 1 0 0",
                         SNOOZE_ACT, SNOOZE_LEFT, RINGING);
    end
    for (int t = 0; t < SNOOZE_SEC; t++) begin
      step();
      pulse_tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL snooze_tick%0d: got %b expected %b", t, dut_vec, model_vec());
      end
    end
    checks++;
    if (STATE !== 2'b01) begin
      errors++; $display("FAIL snooze_return: got %b expected 01", STATE);
    end
    SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
    checks++;
    if (STATE !== 2'b11 || SNOOZE_LEFT !== 4'd0) begin
      errors++; $display("FAIL snooze_limit: got state=%b left=%0d expected 11 0", STATE, SNOOZE_LEFT);
    end
  endtask

  task automatic test_stop_snooze();
    fresh_ring();
    STOP = 1'b1; SNOOZE = 1'b1; step(); STOP = 1'b0; SNOOZE = 1'b0;
    checks++;
    if (STATE !== 2'b11 || SNOOZE_LEFT !== 4'd1 || SNOOZE_ACT !== 1'b0) begin
      errors++; $display("FAIL stop_beats_snooze: got state=%b left=%0d act=%b expected 11 1 0",
                         STATE, SNOOZE_LEFT, SNOOZE_ACT);
    end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (STATE !== 2'b11) begin
        errors++; $display("FAIL done_hold%0d: got %b expected 11", i, STATE);
      end
    end
    CUR_TIME = AFTER;
    step();
    checks++;
    if (STATE !== 2'b00) begin
      errors++; $display("FAIL done_release: got %b expected 00", STATE);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dut_vec !== model_vec() || RINGING !== 1'b0) begin
        errors++; $display("FAIL no_retrigger%0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_tick_collisions();
    fresh_ring();
    pulse_tick(); pulse_tick();
    SEC_TICK = 1'b1; SNOOZE = 1'b1; step(); SEC_TICK = 1'b0; SNOOZE = 1'b0;
    checks++;
    if (STATE !== 2'b10 || SNOOZE_ACT !== 1'b1) begin
      errors++; $display("FAIL timeout_vs_snooze: got state=%b act=%b expected 10 1", STATE, SNOOZE_ACT);
    end
    pulse_tick(); pulse_tick();
    pulse_tick(); pulse_tick();
    SEC_TICK = 1'b1; STOP = 1'b1; step(); SEC_TICK = 1'b0; STOP = 1'b0;
    checks++;
    if (STATE !== 2'b11 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL timeout_with_stop: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_en_drop();
    fresh_ring();
    SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
    ALARM_EN = 1'b0;
    step();
    checks++;
    if (dut_vec !== 9'b000_0000_00) begin
      errors++; $display("FAIL en_drop_snooze: got %b expected 000000000", dut_vec);
    end
    ALARM_EN = 1'b1;
    step();
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL en_restore: got %b expected %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid_ring();
    fresh_ring();
    step(); step(); step(); step(); step();
    #2 RESETN = 1'b0;
    #1;
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL async_reset: got %b expected %b", dut_vec, RST_VEC);
    end
    step();
    RESETN = 1'b1;
    step();
    checks++;
    if (RINGING !== 1'b1 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL ring_after_reset: got %b expected %b", dut_vec, model_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL post_reset%0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_random();
    int r;
    ALARM_TIME = ALM;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) CUR_TIME = ALM;
        else if (r < 6) CUR_TIME = AFTER;
        else if (r < 8) CUR_TIME = BEFORE;
        else CUR_TIME = 17'($urandom);
      end
      ALARM_EN = ($urandom_range(0, 39) != 0);
      SEC_TICK = ($urandom_range(0, 2) == 0);
      STOP     = ($urandom_range(0, 29) == 0);
      SNOOZE   = ($urandom_range(0, 11) == 0);
      RESETN   = ($urandom_range(0, 499) != 0);
      step();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL random%0d: got %b expected %b", i, dut_vec, model_vec());
      end
    end
    RESETN = 1'b1; SEC_TICK = 1'b0; STOP = 1'b0; SNOOZE = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_ring();
    test_snooze();
    test_stop_snooze();
    test_done_hold();
    test_tick_collisions();
    test_en_drop();
    test_reset_mid_ring();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
